// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared loader state type and word geometry
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} loader_state_t;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - packs accepted bytes into a little-endian 32-bit word
module byte_packer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  output logic        word_ready,
  output logic [31:0] word
);
  logic [1:0]  idx_q, idx_d;
  logic [31:0] asm_q, asm_d;

  always_comb begin
    // asm_q upper bytes stay zero until filled, so a short final word is zero-padded
    word       = asm_q | ({24'b0, in_byte} << {idx_q, 3'b000});
    word_ready = accept && (in_last || idx_q == 2'(BYTES_PER_WORD - 1));
    idx_d      = idx_q;
    asm_d      = asm_q;
    if (clear) begin
      idx_d = 2'd0;
      asm_d = 32'd0;
    end else if (accept) begin
      if (word_ready) begin
        idx_d = 2'd0;
        asm_d = 32'd0;
      end else begin
        idx_d = idx_q + 2'd1;
        asm_d = word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= 2'd0;
      asm_q <= 32'd0;
    end else begin
      idx_q <= idx_d;
      asm_q <= asm_d;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte stream to instruction memory loader holding the CPU in reset
// Optional LOADER_CHECKSUM_EN adds sum_out, a modulo-256 sum of bytes accepted since start.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8,
  parameter int MAX_WORDS     = 2 ** (ADDRESS_WIDTH - 2)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_data,
  input  logic                     in_last,
  output logic                     we,
  output logic [ADDRESS_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0]    wdata,
  output logic                     cpu_rst,
  output logic                     busy,
  output logic                     done,
  output logic                     err
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0]               sum_out
`endif
);
  localparam int WIDX_W = ADDRESS_WIDTH - 1;

  loader_state_t            state_q, state_d;
  logic [WIDX_W-1:0]        word_idx_q, word_idx_d;
  logic                     in_ready_q, in_ready_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     cpu_rst_q, cpu_rst_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     clear;
  logic                     accept;
  logic                     pk_word_ready;
  logic [31:0]              pk_word;

  assign accept = in_valid && in_ready_q;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .accept     (accept),
    .in_byte    (in_data),
    .in_last    (in_last),
    .word_ready (pk_word_ready),
    .word       (pk_word)
  );

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    clear      = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = LOAD;
          word_idx_d = '0;
          clear      = 1'b1;
        end
      end
      LOAD: begin
        if (accept) begin
          if (pk_word_ready) begin
            we_d       = 1'b1;
            waddr_d    = {word_idx_q[ADDRESS_WIDTH-3:0], 2'b00};
            wdata_d    = pk_word;
            word_idx_d = word_idx_q + WIDX_W'(1);
          end
          if (in_last) state_d = DONE;
        end else if (in_valid && word_idx_q == WIDX_W'(MAX_WORDS)) begin
          state_d = ERR;
        end
      end
      default: state_d = IDLE;
    endcase
    // Memory full: drop ready ahead of time so an extra byte is refused, not swallowed
    in_ready_d = (state_d == LOAD) && (word_idx_d != WIDX_W'(MAX_WORDS));
    busy_d     = (state_d == LOAD);
    done_d     = (state_d == DONE);
    err_d      = (state_d == ERR);
    cpu_rst_d  = !(state_q == DONE && state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      word_idx_q <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      cpu_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready = in_ready_q;
  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign cpu_rst  = cpu_rst_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear)       sum_d = 8'd0;
    else if (accept) sum_d = sum_q + in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sum_q <= 8'd0;
    else      sum_q <= sum_d;
  end

  assign sum_out = sum_q;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a word-list model
module tb_imem_loader;
  localparam int AW   = 4;
  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready, we, cpu_rst, busy, done, err;
  logic [AW-1:0] waddr;
  logic [31:0] wdata;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  sum_out;
`endif

  int total = 0;
  int bad = 0;
  logic [AW+31:0] obs_q[$];

  imem_loader #(.DATA_WIDTH(32), .ADDRESS_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .cpu_rst  (cpu_rst),
    .busy     (busy),
    .done     (done),
    .err      (err)
`ifdef LOADER_CHECKSUM_EN
    ,
    .sum_out  (sum_out)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (we) obs_q.push_back({waddr, wdata});

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input int gap, output bit ok);
    int n;
    repeat (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    if (ok) @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] b0, input logic l0, input bit overlap);
    @(negedge clk);
    start = 1'b1;
    if (overlap) begin
      in_valid = 1'b1;
      in_data  = b0;
      in_last  = l0;
      chk("idle_rdy", in_ready, 0);
    end
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", {busy, cpu_rst, done, err}, 4'b1100);
`ifdef LOADER_CHECKSUM_EN
    chk("sum_clr", sum_out, 0);
`endif
  endtask

  // mode: 0 back-to-back, 1 alternate idle cycles, 2 random gaps
  task automatic run_load(input logic [7:0] prog[$], input bit with_last, input int mode,
                          input bit overlap);
    int n_acc, n_words, gap;
    bit ok;
    logic [31:0] exp_w[$];
    logic [7:0]  exp_sum;
    n_acc = with_last ? prog.size() : MAXW * 4;
    n_words = (n_acc + 3) / 4;
    exp_sum = 8'd0;
    for (int w = 0; w < n_words; w++) exp_w.push_back(32'd0);
    for (int i = 0; i < n_acc; i++) begin
      exp_w[i/4] = exp_w[i/4] | (32'(prog[i]) << (8 * (i % 4)));
      exp_sum = exp_sum + prog[i];
    end
    obs_q.delete();
    pulse_start(prog[0], with_last && prog.size() == 1, overlap);
    for (int i = 0; i < n_acc; i++) begin
      gap = (mode == 0 || i == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
      send_byte(prog[i], with_last && i == prog.size() - 1, gap, ok);
      chk("handshake", ok, 1);
    end
    if (with_last) begin
      chk("final_cycle", {we, done, cpu_rst, busy}, 4'b1110);
      @(negedge clk);
      chk("cpu_release", {cpu_rst, we, in_ready, done}, 4'b0001);
    end else begin
      in_valid = 1'b1;
      in_data  = prog[n_acc];
      chk("ovf_rdy", in_ready, 0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("ovf_state", {err, in_ready, cpu_rst, busy, done}, 5'b10100);
      @(negedge clk);
    end
    chk("write_count", obs_q.size(), n_words);
    for (int w = 0; w < n_words && w < obs_q.size(); w++)
      chk($sformatf("write%0d", w), obs_q[w], {AW'(w * 4), exp_w[w]});
`ifdef LOADER_CHECKSUM_EN
    chk("sum_out", sum_out, exp_sum);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] p[$];
    bit ok;
    int len;
    repeat (3) @(negedge clk);
    chk("rst_outs", {in_ready, we, waddr, wdata, cpu_rst, busy, done, err},
        {1'b0, 1'b0, AW'(0), 32'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    rst = 1'b1;
    @(negedge clk);

    p = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    run_load(p, 1, 0, 1);
    p = '{8'hAA, 8'hBB, 8'hCC};
    run_load(p, 1, 0, 0);
    p = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(p, 1, 1, 0);
    p = '{8'h5A};
    run_load(p, 1, 2, 0);
    p.delete();
    for (int i = 0; i < 17; i++) p.push_back(8'(i * 7 + 1));
    run_load(p, 0, 0, 0);
    p.delete();
    for (int i = 0; i < 16; i++) p.push_back(8'($urandom));
    run_load(p, 1, 2, 0);
    p = '{8'hFF, 8'h02};
    run_load(p, 1, 0, 0);

    // reset in the middle of a word
    obs_q.delete();
    pulse_start(8'h00, 1'b0, 0);
    send_byte(8'h11, 0, 0, ok);
    send_byte(8'h22, 0, 0, ok);
    #1 rst = 1'b0;
    #1 chk("midrst_outs", {in_ready, we, waddr, cpu_rst, busy, done, err},
           {1'b0, 1'b0, AW'(0), 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_nowrite", obs_q.size(), 0);
    p = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_load(p, 1, 0, 0);

    for (int r = 0; r < 20; r++) begin
      p.delete();
      if ($urandom_range(0, 4) == 0) begin
        for (int i = 0; i < 17; i++) p.push_back(8'($urandom));
        run_load(p, 0, int'($urandom_range(0, 2)), 0);
      end else begin
        len = int'($urandom_range(1, 16));
        for (int i = 0; i < len; i++) p.push_back(8'($urandom));
        run_load(p, 1, int'($urandom_range(0, 2)), $urandom_range(0, 1) == 1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
